// File: rtl/sram_arb_pkg.sv
// Shared encodings and widths for the SRAM port arbiter.
package sram_arb_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable saturating down-counter with a zero flag.
// Used for SRAM wait states and, when SRAM_ARB_STARVE_EN is defined, for IF starvation tracking.
module sram_wait_timer
    import sram_arb_pkg::*;
#(
    parameter logic [WAIT_W-1:0] RESET_VAL = '0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] value,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single asynchronous-read SRAM port between DLX instruction
// fetch (IF) and the MEM stage (DM). DM has fixed priority; each access is held
// for 1+WAIT_CYCLES cycles, then a one-cycle ack is returned to the owner.
// Optional feature macro: SRAM_ARB_STARVE_EN (bounds consecutive DM grants
// while IF waits to MAX_STARVE).
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned MAX_STARVE  = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy
);

    // Both counters are WAIT_W bits wide; reject configurations that would truncate.
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end
    if (MAX_STARVE > 15) begin : g_bad_starve
        $error("MAX_STARVE must be in 0..15");
    end

    arb_state_t state;
    arb_owner_t owner;
    logic       grant_dm;
    logic       grant_if;
    logic       starve_hit;
    logic       wait_zero;

`ifdef SRAM_ARB_STARVE_EN
    logic starve_zero;

    // Counts down from MAX_STARVE on each DM grant taken while IF is waiting;
    // reaching zero hands the next arbitration to IF.
    sram_wait_timer #(
        .RESET_VAL(WAIT_W'(MAX_STARVE))
    ) u_starve_timer (
        .clk   (clk),
        .reset (reset),
        .load  ((state == ST_IDLE) && (grant_if || !if_req)),
        .value (WAIT_W'(MAX_STARVE)),
        .dec   ((state == ST_IDLE) && grant_dm && if_req),
        .zero  (starve_zero)
    );

    assign starve_hit = if_req && starve_zero;
`else
    assign starve_hit = 1'b0;
`endif

    // Fixed DM priority, overridden only by the starvation guard.
    always_comb begin
        grant_dm = dm_req && !starve_hit;
        grant_if = if_req && !grant_dm;
    end

    // Wait-state counter: loaded on every grant, counts down through ACCESS.
    sram_wait_timer #(
        .RESET_VAL('0)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .load  ((state == ST_IDLE) && (grant_dm || grant_if)),
        .value (WAIT_W'(WAIT_CYCLES)),
        .dec   (state == ST_ACCESS),
        .zero  (wait_zero)
    );

    // Arbitration FSM; every output is a register. sram_we doubles as the
    // latched transaction direction, and sram_addr/sram_din hold the latched
    // address/data for the whole ACCESS phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_rdata  <= '0;
            dm_ack    <= 1'b0;
            sram_cs   <= 1'b0;
            sram_oe   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (grant_dm) begin
                        owner     <= OWN_DM;
                        state     <= ST_ACCESS;
                        busy      <= 1'b1;
                        sram_cs   <= 1'b1;
                        sram_we   <= dm_we;
                        sram_oe   <= !dm_we;
                        sram_addr <= dm_addr;
                        sram_din  <= dm_we ? dm_wdata : '0;
                    end else if (grant_if) begin
                        owner     <= OWN_IF;
                        state     <= ST_ACCESS;
                        busy      <= 1'b1;
                        sram_cs   <= 1'b1;
                        sram_we   <= 1'b0;
                        sram_oe   <= 1'b1;
                        sram_addr <= if_addr;
                        sram_din  <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (wait_zero) begin
                        state     <= ST_RESP;
                        sram_cs   <= 1'b0;
                        sram_oe   <= 1'b0;
                        sram_we   <= 1'b0;
                        sram_addr <= '0;
                        sram_din  <= '0;
                        if (owner == OWN_DM) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= sram_we ? '0 : sram_dout;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= sram_dout;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    sram_cs   <= 1'b0;
                    sram_oe   <= 1'b0;
                    sram_we   <= 1'b0;
                    sram_addr <= '0;
                    sram_din  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter (WAIT_CYCLES=2, MAX_STARVE=4).
module tb_sram_port_arbiter;

    localparam int unsigned W  = 2;
    localparam int unsigned MS = 4;
    localparam int         GAP = 3 + W;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        sram_cs, sram_oe, sram_we, busy;
    logic [31:0] sram_addr, sram_din, sram_dout;

    sram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .MAX_STARVE(MS)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Asynchronous-read SRAM model with a few hand-picked contents.
    always_comb begin
        case (sram_addr)
            32'h00400020: sram_dout = 32'h2001AAAA;
            32'h00400024: sram_dout = 32'h3C08BEEF;
            32'h10000004: sram_dout = 32'h12345678;
            default:      sram_dout = ~sram_addr;
        endcase
    end

    typedef struct { bit dm; logic [31:0] rdata; int cyc; } ack_t;
    typedef struct { logic [31:0] addr; bit we; logic [31:0] din; int cyc; } acc_t;

    ack_t ackq[$];
    acc_t accq[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   ack_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue the ack and the SRAM access a transaction granted in cycle g must produce.
    task automatic expect_txn(input bit dm, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int g);
        ack_t a;
        acc_t s;
        a.dm = dm; a.rdata = we ? 32'h0 : rdata; a.cyc = g + 2 + W;
        s.addr = addr; s.we = we; s.din = we ? wdata : 32'h0; s.cyc = g + 1;
        ackq.push_back(a);
        accq.push_back(s);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target);
        int budget = 100;
        while (ack_count < target && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (ack_count < target) chk("ack_timeout", ack_count, target);
    endtask

    // Monitor: pops expectations on every ack and every SRAM access start.
    logic prev_cs = 1'b0, prev_busy = 1'b0;
    int   cs_run = 0, busy_run = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_cs = 1'b0; prev_busy = 1'b0; cs_run = 0; busy_run = 0;
        end else begin
            if (if_ack || dm_ack) begin
                ack_count++;
                chk("single_ack", {31'b0, if_ack & dm_ack}, 32'h0);
                chk("ack_pending", {31'b0, ackq.size() != 0}, 32'h1);
                if (ackq.size() != 0) begin
                    ack_t e;
                    e = ackq.pop_front();
                    chk("ack_owner", {31'b0, dm_ack}, {31'b0, e.dm});
                    chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.rdata);
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
            if (sram_cs && !prev_cs) begin
                chk("acc_pending", {31'b0, accq.size() != 0}, 32'h1);
                if (accq.size() != 0) begin
                    acc_t s;
                    s = accq.pop_front();
                    chk("sram_addr", sram_addr, s.addr);
                    chk("sram_we_oe", {30'b0, sram_we, sram_oe}, {30'b0, s.we, !s.we});
                    chk("sram_din", sram_din, s.din);
                    chk("sram_start", cyc, s.cyc);
                end
            end
            if (sram_cs) cs_run++;
            else if (prev_cs) begin
                chk("cs_length", cs_run, W + 1);
                cs_run = 0;
            end
            if (busy) busy_run++;
            else if (prev_busy) begin
                chk("busy_length", busy_run, W + 2);
                busy_run = 0;
            end
            prev_cs = sram_cs;
            prev_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) next_cycle();
        chk("reset_ctrl", {26'b0, if_ack, dm_ack, sram_cs, sram_oe, sram_we, busy}, 32'h0);
        chk("reset_data", sram_addr | sram_din | if_rdata | dm_rdata, 32'h0);
        reset = 1'b0;
        next_cycle();

        // Instruction fetch read.
        c = cyc;
        expect_txn(0, 0, 32'h00400020, 32'h0, 32'h2001AAAA, c);
        if_req = 1'b1; if_addr = 32'h00400020;
        wait_acks(1);
        if_req = 1'b0;

        // Data write: rdata reported as zero, IF data must hold.
        next_cycle();
        c = cyc;
        expect_txn(1, 1, 32'h10000000, 32'hDEADBEEF, 32'h0, c);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10000000; dm_wdata = 32'hDEADBEEF;
        wait_acks(2);
        dm_req = 1'b0; dm_we = 1'b0;
        chk("if_rdata_hold", if_rdata, 32'h2001AAAA);

        // Data read.
        next_cycle();
        c = cyc;
        expect_txn(1, 0, 32'h10000004, 32'h0, 32'h12345678, c);
        dm_req = 1'b1; dm_addr = 32'h10000004;
        wait_acks(3);
        dm_req = 1'b0;

        // Simultaneous requests: DM first, IF granted in the following IDLE.
        next_cycle();
        c = cyc;
        expect_txn(1, 0, 32'h10000008, 32'h0, 32'hEFFFFFF7, c);
        expect_txn(0, 0, 32'h00400024, 32'h0, 32'h3C08BEEF, c + GAP);
        dm_req = 1'b1; dm_addr = 32'h10000008;
        if_req = 1'b1; if_addr = 32'h00400024;
        wait_acks(4);
        dm_req = 1'b0;
        wait_acks(5);
        if_req = 1'b0;

        // IF request held across its ack: one ack per transaction, regrant at ack+1.
        next_cycle();
        c = cyc;
        expect_txn(0, 0, 32'h00400020, 32'h0, 32'h2001AAAA, c);
        expect_txn(0, 0, 32'h00400020, 32'h0, 32'h2001AAAA, c + GAP);
        if_req = 1'b1; if_addr = 32'h00400020;
        wait_acks(7);
        if_req = 1'b0;

        // Request withdrawn early: the latched access still completes and acks.
        next_cycle();
        c = cyc;
        expect_txn(0, 0, 32'h00400024, 32'h0, 32'h3C08BEEF, c);
        if_req = 1'b1; if_addr = 32'h00400024;
        next_cycle();
        if_req = 1'b0;
        wait_acks(8);

        // Reset in the middle of ACCESS: everything clears at once, no ack.
        next_cycle();
        c = cyc;
        begin
            acc_t s;
            s.addr = 32'h10000004; s.we = 0; s.din = 32'h0; s.cyc = c + 1;
            accq.push_back(s);
        end
        dm_req = 1'b1; dm_addr = 32'h10000004;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        chk("abort_ctrl", {26'b0, if_ack, dm_ack, sram_cs, sram_oe, sram_we, busy}, 32'h0);
        chk("abort_data", sram_addr | sram_din | if_rdata | dm_rdata, 32'h0);
        dm_req = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        repeat (3) next_cycle();
        c = cyc;
        expect_txn(1, 1, 32'h10000010, 32'hCAFEF00D, 32'h0, c);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10000010; dm_wdata = 32'hCAFEF00D;
        wait_acks(9);
        dm_req = 1'b0; dm_we = 1'b0;

        // Both requesters continuously active.
        next_cycle();
        c = cyc;
        for (int k = 0; k < 10; k++) begin
            bit dmk;
`ifdef SRAM_ARB_STARVE_EN
            dmk = (k % 5) != 4;
`else
            dmk = 1'b1;
`endif
            expect_txn(dmk, 0, dmk ? 32'h10000004 : 32'h00400020, 32'h0,
                       dmk ? 32'h12345678 : 32'h2001AAAA, c + k * GAP);
        end
        dm_req = 1'b1; dm_addr = 32'h10000004;
        if_req = 1'b1; if_addr = 32'h00400020;
        wait_acks(19);
        dm_req = 1'b0; if_req = 1'b0;

        repeat (5) next_cycle();
        chk("ackq_drained", ackq.size(), 32'h0);
        chk("accq_drained", accq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single asynchronous-read SRAM port (cs/oe/we/addr/din/dout) between the DLX pipeline's instruction-fetch stage and its MEM stage.
- Serialises the two requesters and grants the data port fixed priority.
- Inserts a programmable number of SRAM wait cycles.
- Presents each requester a req/ack handshake, so IF or MEM stalls until its ack.

Parameters:
- ADDR_W, 32, address width on all address ports.
- DATA_W, 32, data width on all data ports.
- WAIT_CYCLES, 0, extra SRAM access cycles beyond the first (0..15).
- MAX_STARVE, 4, consecutive MEM grants allowed while IF waits; used only with SRAM_ARB_STARVE_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse to fetch.
- dm_req  in  1  data request; dm_we, dm_addr and dm_wdata held until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid while dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse to MEM.
- sram_cs  out  1  SRAM chip select.
- sram_oe  out  1  SRAM output enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_din  out  DATA_W  SRAM write data.
- sram_dout  in  DATA_W  SRAM read data, combinational from sram_addr.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered. On reset (asynchronous, active-high) every output is 0 and state is IDLE.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If dm_req=1: grant MEM, latch dm_we, dm_addr and dm_wdata.
  - Else if if_req=1: grant IF, latch if_addr with we=0.
  - Else stay in IDLE.
  - On a grant, load the wait counter with WAIT_CYCLES and move to ACCESS.
- ACCESS:
  - sram_cs=1, sram_addr=latched addr.
  - sram_oe=!we, sram_we=we, sram_din=latched wdata when we=1, else 0.
  - The counter decrements each cycle. When it is 0, capture sram_dout (reads only) and move to RESP.
- RESP:
  - All sram_* outputs are 0.
  - Pulse the owner's ack for exactly one cycle; the owner's rdata holds the captured word (0 for writes).
  - Return to IDLE unconditionally. Requests are never sampled in RESP, so a still-high req from the acked owner cannot double-grant.
- Latency: a req seen in IDLE at cycle 0 produces sram access during cycles 1..1+WAIT_CYCLES and ack at cycle 2+WAIT_CYCLES. The minimum spacing between grants is 3+WAIT_CYCLES cycles.
- Simultaneous if_req and dm_req in IDLE: MEM always wins; IF stays pending with no ack.
- A req that deasserts before its ack is a protocol violation. The latched transaction completes anyway, and the ack is still issued.
- if_rdata and dm_rdata hold their last value outside ack cycles. They are cleared only by reset.
- Reset during ACCESS or RESP aborts the transaction: no ack, sram_cs and sram_we drop immediately (asynchronously).
- No address arithmetic: addresses pass through unmodified, with no alignment check.

Optional Feature:
- SRAM_ARB_STARVE_EN defined:
  - A 4-bit starve counter increments on each MEM grant made while if_req=1.
  - It clears on any IF grant or when if_req=0 in IDLE.
  - When the counter reaches MAX_STARVE, the next IDLE arbitration grants IF even if dm_req=1.
- SRAM_ARB_STARVE_EN undefined: strict MEM priority; no counter logic is present.

Decomposition:
- Shared package sram_arb_pkg:
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2.
  - owner encodings OWN_IF=1'b0, OWN_DM=1'b1.
  - WAIT_W=4.
- One sub-module, sram_wait_timer:
  - loadable down-counter with load/value inputs and a zero flag.
  - also instantiated for the starve counter when SRAM_ARB_STARVE_EN is defined.

Test Plan:
- WAIT_CYCLES=0; if_req=1, if_addr=32'h00400020, with the SRAM model returning 32'h2001AAAA: sram_cs=1 in cycle 1, if_ack=1 in cycle 2 with if_rdata=32'h2001AAAA, busy high in cycles 1-2.
- WAIT_CYCLES=2; dm write dm_addr=32'h10000000, dm_wdata=32'hDEADBEEF: sram_we=1, sram_oe=0 and sram_din=32'hDEADBEEF for exactly 3 cycles; dm_ack in cycle 4 with dm_rdata=0.
- if_req and dm_req asserted together in the same cycle: MEM access completes first (dm_ack in cycle 2); IF is granted in the next IDLE (if_ack in cycle 5); no cycle has both acks.
- Reset asserted mid-ACCESS with WAIT_CYCLES=3: all outputs 0 at once, no ack. A request after reset release completes normally.
- if_req held high across its ack: exactly one if_ack per transaction, next grant no earlier than ack+1.
- SRAM_ARB_STARVE_EN, MAX_STARVE=4, dm_req and if_req continuously high: grant sequence is DM,DM,DM,DM,IF,DM... repeating.
